// File: rtl/conv2_ctrl.sv
// conv2 sequencer: walks the 10x10 output grid and 5x5 kernel, drives S2/weight reads,
// MAC clear/enable and F4 writes. Optional address-generation stall: CONV2_CTRL_HOLD_EN.
module conv2_ctrl #(
  parameter int IN_W     = 14,
  parameter int OUT_W    = 10,
  parameter int K        = 5,
  parameter int PIPE_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] s2_raddr,
  output logic [4:0] w_raddr,
  output logic       mac_clr,
  output logic       mac_en,
  output logic       f4_we,
  output logic [6:0] f4_waddr,
  output logic       busy,
  output logic       done
`ifdef CONV2_CTRL_HOLD_EN
  ,
  input  logic       hold
`endif
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one kernel tap issued per cycle
  // DRAIN | taps finished, waiting for the final F4 write
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int KW = $clog2(K);
  localparam int OW = $clog2(OUT_W);

  state_t        state;
  logic [KW-1:0] kx, ky;
  logic [OW-1:0] ox, oy;
  logic [7:0]    line_base, pix_base, row_base;
  logic [6:0]    pix_idx;

  logic [PIPE_LAT-1:0] we_dl;
  logic [6:0]          addr_dl [PIPE_LAT];

  logic stall;
`ifdef CONV2_CTRL_HOLD_EN
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif

  logic adv, first_tap, last_tap, kx_end, ky_end, ox_end, oy_end;
  assign adv       = (state == RUN) && !stall;
  assign kx_end    = (kx == KW'(K - 1));
  assign ky_end    = (ky == KW'(K - 1));
  assign ox_end    = (ox == OW'(OUT_W - 1));
  assign oy_end    = (oy == OW'(OUT_W - 1));
  assign first_tap = (kx == '0) && (ky == '0);
  assign last_tap  = kx_end && ky_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      kx        <= '0;
      ky        <= '0;
      ox        <= '0;
      oy        <= '0;
      line_base <= '0;
      pix_base  <= '0;
      row_base  <= '0;
      pix_idx   <= '0;
      s2_raddr  <= '0;
      w_raddr   <= '0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      f4_we     <= 1'b0;
      f4_waddr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      we_dl     <= '0;
      for (int i = 0; i < PIPE_LAT; i++) addr_dl[i] <= '0;
    end else begin
      // Read data arrives one cycle after the address, so MAC strobes lag by one.
      mac_en  <= adv;
      mac_clr <= adv && first_tap;

      // The datapath pipeline cannot stall, so this line shifts every cycle.
      we_dl[0]   <= adv && last_tap;
      addr_dl[0] <= pix_idx;
      for (int i = 1; i < PIPE_LAT; i++) begin
        we_dl[i]   <= we_dl[i-1];
        addr_dl[i] <= addr_dl[i-1];
      end
      f4_we <= we_dl[PIPE_LAT-1];
      if (we_dl[PIPE_LAT-1]) f4_waddr <= addr_dl[PIPE_LAT-1];
      done <= we_dl[PIPE_LAT-1] && (addr_dl[PIPE_LAT-1] == 7'(OUT_W * OUT_W - 1));

      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!stall) begin
            w_raddr <= last_tap ? 5'd0 : w_raddr + 5'd1;
            if (!kx_end) begin
              kx       <= kx + 1'b1;
              s2_raddr <= s2_raddr + 8'd1;
            end else if (!ky_end) begin
              kx       <= '0;
              ky       <= ky + 1'b1;
              row_base <= row_base + 8'(IN_W);
              s2_raddr <= row_base + 8'(IN_W);
            end else if (!ox_end) begin
              kx       <= '0;
              ky       <= '0;
              ox       <= ox + 1'b1;
              pix_base <= pix_base + 8'd1;
              row_base <= pix_base + 8'd1;
              s2_raddr <= pix_base + 8'd1;
              pix_idx  <= pix_idx + 7'd1;
            end else if (!oy_end) begin
              kx        <= '0;
              ky        <= '0;
              ox        <= '0;
              oy        <= oy + 1'b1;
              line_base <= line_base + 8'(IN_W);
              pix_base  <= line_base + 8'(IN_W);
              row_base  <= line_base + 8'(IN_W);
              s2_raddr  <= line_base + 8'(IN_W);
              pix_idx   <= pix_idx + 7'd1;
            end else begin
              // Final tap: rewind everything so the next run starts from zero.
              kx        <= '0;
              ky        <= '0;
              ox        <= '0;
              oy        <= '0;
              line_base <= '0;
              pix_base  <= '0;
              row_base  <= '0;
              s2_raddr  <= '0;
              pix_idx   <= '0;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
